// File: rtl/pipo_rr_arbiter.sv
// rtl/pipo_rr_arbiter.sv - four-way round-robin arbiter feeding one shared holding register
module pipo_rr_arbiter #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] data3,
  output logic [3:0]       grant,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic [1:0]       out_src,
  input  logic             out_ready,
  output logic [CNT_W-1:0] xfer_count
);

  typedef enum logic {IDLE = 1'b0, FULL = 1'b1} state_t;

  state_t           state, state_nx;
  logic [1:0]       last_grant;
  logic [1:0]       winner;
  logic [1:0]       idx;
  logic             found;
  logic             can_load;
  logic             load;
  logic [WIDTH-1:0] win_data;

  // Scan starts one past the previous winner, so the last winner has lowest priority.
  always_comb begin
    winner = last_grant;
    found  = 1'b0;
    idx    = last_grant;
    for (int k = 1; k <= 4; k++) begin
      idx = last_grant + 2'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign can_load = (state == IDLE) | out_ready;
  assign load     = can_load & (|req);

  always_comb begin
    grant = '0;
    if (load) grant[winner] = 1'b1;
  end

  always_comb begin
    case (winner)
      2'd0:    win_data = data0;
      2'd1:    win_data = data1;
      2'd2:    win_data = data2;
      default: win_data = data3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (load)                         state_nx = FULL;
    else if (state == FULL && out_ready) state_nx = IDLE;
  end

  always_comb begin
    out_valid = (state == FULL);
  end

  // Holding register keeps its word and source after the consumer drains it.
  always_ff @(posedge clk) begin
    if (reset) begin
      parallel_out <= '0;
      out_src      <= 2'd0;
      last_grant   <= 2'd3;
      xfer_count   <= '0;
    end else if (load) begin
      parallel_out <= win_data;
      out_src      <= winner;
      last_grant   <= winner;
      xfer_count   <= xfer_count + 1'b1;
    end
  end

endmodule
